// File: rtl/exec_muldiv.sv
// Iterative radix-2 RV64M multiply/divide unit for the execute stage.
// Produces one product or quotient bit per cycle; W ops run half the iterations.
module exec_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // Handshake: execute holds valid with the same op while busy is high; the op is
  // taken on the first edge with valid & !flush in IDLE. done pulses for exactly one
  // cycle with result, and the pipeline advances on it. flush squashes without done.

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  localparam logic [CW-1:0]   LAST_D = CW'(XLEN - 1);
  localparam logic [CW-1:0]   LAST_W = CW'(HALF - 1);
  localparam logic [XLEN-1:0] MIN_D  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W  = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_REM   = 4'd3;
  localparam logic [3:0] OP_REMU  = 4'd4;
  localparam logic [3:0] OP_MULW  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic f_mul(input logic [3:0] o);
    return (o == OP_MUL) || (o == OP_MULW);
  endfunction

  function automatic logic f_w(input logic [3:0] o);
    return (o >= OP_MULW) && (o <= OP_REMUW);
  endfunction

  function automatic logic f_rem(input logic [3:0] o);
    return (o == OP_REM) || (o == OP_REMU) || (o == OP_REMW) || (o == OP_REMUW);
  endfunction

  function automatic logic f_sgn(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_REM) || (o == OP_DIVW) || (o == OP_REMW);
  endfunction

  function automatic logic [XLEN-1:0] f_sext(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Accept-time decode of the incoming operation and its special cases.
  logic            in_w, in_mul, in_rem, in_sgn, in_rsvd;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd_ext, spec_val;
  logic            a_neg, b_neg, div0, ovf;

  always_comb begin
    in_w    = f_w(op);
    in_mul  = f_mul(op);
    in_rem  = f_rem(op);
    in_sgn  = f_sgn(op);
    in_rsvd = (op > OP_REMUW);
    a_ext   = in_w ? (in_sgn ? f_sext(a[HALF-1:0]) : {{HALF{1'b0}}, a[HALF-1:0]}) : a;
    b_ext   = in_w ? (in_sgn ? f_sext(b[HALF-1:0]) : {{HALF{1'b0}}, b[HALF-1:0]}) : b;
    a_neg   = in_sgn & a_ext[XLEN-1];
    b_neg   = in_sgn & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    div0    = (b_ext == '0);
    ovf     = in_sgn & (a_ext == (in_w ? MIN_W : MIN_D)) & (b_ext == '1);
    // Both special results are defined against the sign-extended dividend for W ops.
    dvd_ext = in_w ? f_sext(a[HALF-1:0]) : a;
    if (div0) begin
      spec_val = in_rem ? dvd_ext : '1;
    end else begin
      spec_val = in_rem ? '0 : dvd_ext;
    end
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  logic [XLEN-1:0] opa_n, opb_n, acc_n, sh_lo;
  logic            ge;

  always_comb begin
    sh_lo = {acc_q[XLEN-2:0], opa_q[XLEN-1]};
    ge    = acc_q[XLEN-1] | (sh_lo >= opb_q);
    if (f_mul(op_q)) begin
      acc_n = acc_q + (opb_q[0] ? opa_q : '0);
      opa_n = opa_q << 1;
      opb_n = opb_q >> 1;
    end else begin
      acc_n = ge ? (sh_lo - opb_q) : sh_lo;
      opa_n = {opa_q[XLEN-2:0], ge};
      opb_n = opb_q;
    end
  end

  // Sign fix-up and width selection applied to the final iteration's values.
  logic [XLEN-1:0] q_fix, r_fix, fin_val, fin_res;

  always_comb begin
    q_fix   = qneg_q ? -opa_n : opa_n;
    r_fix   = rneg_q ? -acc_n : acc_n;
    fin_val = f_mul(op_q) ? acc_n : (f_rem(op_q) ? r_fix : q_fix);
    fin_res = f_w(op_q) ? f_sext(fin_val[HALF-1:0]) : fin_val;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid && !flush) begin
          busy  = 1'b1;
          op_d  = op;
          cnt_d = '0;
          if (in_rsvd) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = '0;
          end else if (!in_mul && (div0 || ovf)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = spec_val;
          end else begin
            state_d = S_CALC;
            acc_d   = '0;
            if (in_mul) begin
              opa_d  = a;
              opb_d  = b;
              qneg_d = 1'b0;
              rneg_d = 1'b0;
            end else begin
              // W dividends sit in the upper half so 32 shifts consume all their bits.
              opa_d  = in_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
              opb_d  = b_mag;
              qneg_d = a_neg ^ b_neg;
              rneg_d = a_neg;
            end
          end
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          opa_d = opa_n;
          opb_d = opb_n;
          acc_d = acc_n;
          if (cnt_q == (f_w(op_q) ? LAST_W : LAST_D)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = fin_res;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Self-checking bench for exec_muldiv: directed plan vectors plus randomized ops
// compared every cycle against an arithmetic reference model.
module tb_exec_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, valid;
  logic [3:0]  op_i;
  logic [63:0] a_i, b_i;
  logic        busy, done;
  logic [63:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  exec_muldiv #(.XLEN(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .valid  (valid),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua, ub, r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua = a[31:0]; ub = b[31:0];
    r = '0; r32 = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: if (b == 0) r = ALL1; else if (a == MIN64 && b == ALL1) r = a; else r = sa / sb;
      4'd2: if (b == 0) r = ALL1; else r = a / b;
      4'd3: if (b == 0) r = a; else if (a == MIN64 && b == ALL1) r = '0; else r = sa % sb;
      4'd4: if (b == 0) r = a; else r = a % b;
      4'd5: begin r32 = ua * ub; r = sx(r32); end
      4'd6: begin
        if (ub == 0) r = ALL1;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = sx(ua);
        else begin r32 = sa32 / sb32; r = sx(r32); end
      end
      4'd7: if (ub == 0) r = ALL1; else begin r32 = ua / ub; r = sx(r32); end
      4'd8: begin
        if (ub == 0) r = sx(ua);
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = '0;
        else begin r32 = sa32 % sb32; r = sx(r32); end
      end
      4'd9: if (ub == 0) r = sx(ua); else begin r32 = ua % ub; r = sx(r32); end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycle (accept edge ends cycle 0) in which done is expected.
  function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
    bit w, sgn, zero, ovf;
    if (op > 4'd9) return 1;
    w    = (op >= 4'd5);
    if (op == 4'd0) return 65;
    if (op == 4'd5) return 33;
    sgn  = (op == 4'd1) || (op == 4'd3) || (op == 4'd6) || (op == 4'd8);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == MIN64 && b == ALL1));
    if (zero || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  // Model state: 0 idle, 1 computing, 2 result presented.
  int          m_phase = 0;
  int          m_cycle = 0;
  int          m_lat   = 0;
  logic [63:0] m_result = '0;
  logic [63:0] exp_q[$];
  bit          chk_en = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_result = '0; exp_q.delete(); chk_en = 1'b1;
      end else begin
        case (m_phase)
          0: if (valid && !flush) begin
            exp_q.push_back(ref_result(op_i, a_i, b_i));
            m_lat   = ref_latency(op_i, a_i, b_i);
            m_cycle = 1;
            if (m_lat == 1) begin m_phase = 2; m_result = exp_q.pop_front(); end
            else m_phase = 1;
          end
          1: if (flush) begin
            m_phase = 0; exp_q.delete();
          end else begin
            m_cycle++;
            if (m_cycle == m_lat) begin m_phase = 2; m_result = exp_q.pop_front(); end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  initial begin : compare
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_busy = (m_phase == 0 && valid && !flush) || (m_phase == 1);
        check("busy", 64'(busy), 64'(exp_busy));
        check("done", 64'(done), 64'(m_phase == 2));
        check("result", result, m_result);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int flush_at, input int reset_at,
                       output int lat_seen, output logic [63:0] res);
    lat_seen = -1; res = '0;
    @(posedge clk); #1;
    valid = 1'b1; op_i = op; a_i = a; b_i = b;
    for (int cyc = 0; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (done) begin lat_seen = cyc; res = result; break; end
      if (flush_at >= 0 && cyc >= flush_at + 4) break;
      if (reset_at >= 0 && cyc >= reset_at + 4) break;
      @(posedge clk); #1;
      // Operands wander after accept; the unit must work from its latched copy.
      a_i  = {$urandom, $urandom};
      b_i  = {$urandom, $urandom};
      op_i = 4'($urandom_range(0, 15));
      if (cyc + 1 == flush_at) flush = 1'b1;
      if (cyc + 1 == flush_at + 1) begin flush = 1'b0; valid = 1'b0; end
      if (cyc + 1 == reset_at) begin reset = 1'b1; valid = 1'b0; end
      if (cyc + 1 == reset_at + 1) reset = 1'b0;
    end
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return ALL1;
      2: return MIN64;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t        dir[$];
  int          lat, elat, fat;
  logic [63:0] res, eres, ra, rb;
  logic [3:0]  rop;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b1; flush = 1'b0; valid = 1'b0; op_i = '0; a_i = '0; b_i = '0;

    // Pin the reference model to hand-computed values.
    check("model_mul", ref_result(4'd0, 64'd7, -64'd3), 64'hFFFF_FFFF_FFFF_FFEB);
    check("model_div", ref_result(4'd1, -64'd20, 64'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    check("model_rem", ref_result(4'd3, -64'd20, 64'd3), 64'hFFFF_FFFF_FFFF_FFFE);
    check("model_remw_ovf", ref_result(4'd8, 64'h8000_0000, ALL1), 64'd0);
    check("model_divuw", ref_result(4'd7, 64'hFFFF_FFFE, 64'd1), 64'hFFFF_FFFF_FFFF_FFFE);
    check("model_lat_w", 64'(ref_latency(4'd7, 64'd5, 64'd1)), 64'd33);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);

    dir.push_back('{4'd0,  64'd7,                  -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    dir.push_back('{4'd1,  -64'd20,                64'd3,  64'hFFFF_FFFF_FFFF_FFFA, 65});
    dir.push_back('{4'd3,  -64'd20,                64'd3,  64'hFFFF_FFFF_FFFF_FFFE, 65});
    dir.push_back('{4'd4,  64'd20,                 64'd3,  64'd2,                   65});
    dir.push_back('{4'd7,  64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    dir.push_back('{4'd5,  64'h1_0000,             64'h1_0000, 64'd0,               33});
    dir.push_back('{4'd12, 64'd123,                64'd456, 64'd0,                  1});
    dir.push_back('{4'd8,  64'h8000_0000,          ALL1,   64'd0,                   1});
    dir.push_back('{4'd1,  MIN64,                  ALL1,   MIN64,                   1});
    dir.push_back('{4'd1,  64'd5,                  64'd0,  ALL1,                    1});
    dir.push_back('{4'd3,  64'd5,                  64'd0,  64'd5,                   1});

    foreach (dir[i]) begin
      issue(dir[i].op, dir[i].a, dir[i].b, -1, -1, lat, res);
      check($sformatf("dir%0d_lat", i), 64'(lat), 64'(dir[i].lat));
      check($sformatf("dir%0d_res", i), res, dir[i].exp);
    end

    // Flush in CALC: no done, result keeps the previous value (5).
    issue(4'd1, 64'd100, 64'd7, 10, -1, lat, res);
    check("flush_no_done", 64'(lat), -64'd1);
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_result", result, 64'd5);

    // Flush coincident with valid in IDLE: nothing accepted.
    @(posedge clk); #1;
    valid = 1'b1; flush = 1'b1; op_i = 4'd0; a_i = 64'd3; b_i = 64'd4;
    @(negedge clk);
    check("flush_valid_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("flush_valid_done", 64'(done), 64'd0);
      check("flush_valid_busy2", 64'(busy), 64'd0);
    end

    // Reset mid-multiply, then a fresh multiply.
    issue(4'd0, 64'd7, 64'd9, -1, 20, lat, res);
    check("reset_mid_no_done", 64'(lat), -64'd1);
    @(negedge clk);
    check("reset_mid_result", result, 64'd0);
    issue(4'd0, 64'd3, 64'd4, -1, -1, lat, res);
    check("after_reset_lat", 64'(lat), 64'd65);
    check("after_reset_res", res, 64'd12);

    // Randomized operations, occasionally flushed mid-computation.
    for (int i = 0; i < 80; i++) begin
      rop  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ra   = rand_opnd();
      rb   = rand_opnd();
      elat = ref_latency(rop, ra, rb);
      eres = ref_result(rop, ra, rb);
      fat  = -1;
      if (elat > 1 && $urandom_range(0, 7) == 0) fat = $urandom_range(1, elat - 1);
      issue(rop, ra, rb, fat, -1, lat, res);
      if (fat < 0) begin
        check($sformatf("rand%0d_lat op%0d", i, rop), 64'(lat), 64'(elat));
        check($sformatf("rand%0d_res op%0d", i, rop), res, eres);
      end else begin
        check($sformatf("rand%0d_flush", i), 64'(lat), -64'd1);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_muldiv.md
Name: exec_muldiv

Overview:
- Iterative RV64M multiply/divide unit inside the execute stage, directly upstream of the memory stage.
- Accepts one operation from decode/execute and computes it over multiple cycles. Holds the execute stage while it runs, then presents a 64-bit result that execute places in its ALU-output field for the memory stage.
- Radix-2: one quotient bit or one partial-product bit per cycle.

Parameters:
- XLEN, 64, operand/result width. W-variants operate on XLEN/2 bits. Only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash in-flight op (branch/exception redirect)
- valid  in  1  execute holds a muldiv instruction this cycle
- op  in  4  0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5 MULW, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10-15 reserved
- a  in  XLEN  rs1 value
- b  in  XLEN  rs2 value
- busy  out  1  stall request to the pipeline (combinational)
- done  out  1  result valid, 1-cycle pulse (registered)
- result  out  XLEN  final value, held until the next accept

Behaviour:
- Reset values: state=IDLE, done=0, result=0, counter=0, internal regs=0. Reset mid-operation aborts immediately with no done pulse.
- States are IDLE, CALC and DONE.
- IDLE:
  - If valid & !flush at an edge, latch op, a and b, then go to CALC. Special cases go straight to DONE.
  - Accepting also clears the counter.
  - reserved op: go to DONE with result=0.
- CALC:
  - One iteration per cycle.
  - 64-bit ops run 64 cycles; W ops run 32 cycles.
  - After the last iteration, go to DONE.
- DONE:
  - done=1 and result is valid.
  - Unconditionally go to IDLE next edge; the pipeline advances on done.
- busy = (state==IDLE & valid & !flush) | state==CALC.
  - busy=0 in DONE.
- Latency, with the accept edge ending cycle 0:
  - 64-bit ops: done in cycle 65.
  - W ops: done in cycle 33.
  - Special cases: done in cycle 1.
- flush:
  - In CALC or DONE, go to IDLE next edge.
  - No done pulse if flushed in CALC.
  - result is unchanged.
  - flush in the same cycle as valid in IDLE means no accept.
- Multiply (MUL, MULW):
  - Shift-add on the unsigned low bits; signedness is irrelevant for the low half.
  - MUL = product[63:0].
  - MULW = sext(product_of_low32[31:0]).
- Divide, restoring, on magnitudes:
  - Signed ops convert operands to absolute values.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- W-variants:
  - Operands are a[31:0] and b[31:0], sign- or zero-extended per op.
  - Result = sext of the 32-bit result, including DIVUW/REMUW.
- Special cases (width-local, evaluated at accept):
  - Divide by zero: quotient = all ones (-1 sign-extended); remainder = dividend (sext for W).
  - Signed overflow (most negative / -1): quotient = dividend; remainder = 0.
- New valid while in CALC/DONE is ignored; the pipeline is stalled, so it is the same instruction.

Test Plan:
- Reset, then MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> busy 1 for cycles 0-64; done in cycle 65 with result 0xFFFF_FFFF_FFFF_FFEB (-21).
- DIV a=-20, b=3 -> result -6 (0xFFFF_FFFF_FFFF_FFFA); REM same operands -> result -2 (0xFFFF_FFFF_FFFF_FFFE); REMU a=20, b=3 -> 2; each done at cycle 65.
- DIVUW a=0x0000_0000_FFFF_FFFE, b=1 -> result 0xFFFF_FFFF_FFFF_FFFE (sext) with done at cycle 33. MULW a=0x10000, b=0x10000 -> 0.
- Special cases, each with done at cycle 1:
  - DIV a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000.
  - REMW a=0x8000_0000, b=-1 -> 0.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11, busy 0, no done, result keeps its prior value. Flush coincident with valid in IDLE -> nothing accepted.
- Reset asserted at cycle 20 of a MUL -> done never pulses, result=0 after the edge. A new MUL a=3, b=4 then completes at cycle 65 with result 12.
